// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_ctrl
// Purpose  : Three-channel PWM generator for the RGB LED path. Duty values
//            are written over a valid/ready port into a shadow buffer. They
//            become active only at a PWM period boundary (wrap), so a period
//            is never glitched mid-way.
// Ports    : clk, rst_n (async, active low)
//            enable                   0 forces pwm_* low; counters keep running
//            wr_valid / wr_ready      duty write handshake
//            wr_red/green/blue        new duty values (COUNTER_BITS wide)
//            pwm_red/green/blue       registered PWM outputs
//            period_strobe            1-clk pulse, one per PWM period
// Config   : `define RGB_PWM_BREATHE_EN adds an 8-bit triangle "breathe"
//            envelope. This envelope scales every duty value at each wrap.
// Revision : 1.0  initial release
// ============================================================================
module rgb_pwm_ctrl #(
  parameter int COUNTER_BITS         = 16,
  parameter int PRESCALER            = 10,
  parameter int BREATHE_STEP_PERIODS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [COUNTER_BITS-1:0] wr_red,
  input  logic [COUNTER_BITS-1:0] wr_green,
  input  logic [COUNTER_BITS-1:0] wr_blue,
  output logic                    pwm_red,
  output logic                    pwm_green,
  output logic                    pwm_blue,
  output logic                    period_strobe
);

  localparam int CB   = COUNTER_BITS;
  localparam int PS_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALER - 1);

  generate
    if (PRESCALER < 1 || BREATHE_STEP_PERIODS < 1) begin : g_bad_params
      $error("rgb_pwm_ctrl: PRESCALER and BREATHE_STEP_PERIODS must be >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PS_W-1:0]  ps_cnt;
  logic [CB-1:0]    pwm_cnt;
  logic             tick;
  logic             wrap;
  logic             accept;
  logic             apply;
  logic [2:0][CB-1:0] wr_data;
  logic [2:0][CB-1:0] shadow;
  logic [2:0][CB-1:0] active;
  logic [2:0][CB-1:0] active_nxt;
  logic [2:0][CB-1:0] eff;
  logic [2:0]         pwm;

  assign wr_data = {wr_blue, wr_green, wr_red};
  assign tick    = (ps_cnt == PS_LAST);
  assign wrap    = tick && (pwm_cnt == {CB{1'b1}});

  // Timebase: prescaler and PWM counter run regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt  <= '0;
      pwm_cnt <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + CB'(1);
      end
    end
  end

  // Write FSM: next state and handshake.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          accept    = 1'b1;
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // A write taken on a wrap clk lands here and waits for the next wrap.
        if (wrap) begin
          apply     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign active_nxt = apply ? shadow : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      shadow <= '0;
      active <= '0;
    end else begin
      state  <= state_nxt;
      active <= active_nxt;
      if (accept) begin
        shadow <= wr_data;
      end
    end
  end

`ifdef RGB_PWM_BREATHE_EN
  localparam int STEP_W = (BREATHE_STEP_PERIODS > 1) ? $clog2(BREATHE_STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BREATHE_STEP_PERIODS - 1);
  localparam int PW = CB + 8;

  logic [STEP_W-1:0]  step_cnt;
  logic [7:0]         env, env_nxt;
  logic               env_down, env_down_nxt;
  logic               env_step;
  logic [2:0][PW-1:0] prod;

  assign env_step = wrap && (step_cnt == STEP_LAST);

  // Triangle envelope. At 255 and 0 the step only flips direction, so each
  // endpoint is held for one extra step (full cycle = 512 steps).
  always_comb begin
    env_nxt      = env;
    env_down_nxt = env_down;
    if (env_step) begin
      if (!env_down) begin
        if (env == 8'hFF) env_down_nxt = 1'b1;
        else              env_nxt      = env + 8'd1;
      end else begin
        if (env == 8'h00) env_down_nxt = 1'b0;
        else              env_nxt      = env - 8'd1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      prod[i] = PW'(active_nxt[i]) * PW'(env_nxt);
    end
  end

  // Scaled duty is latched at wrap, from the values the new period will use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      env      <= '0;
      env_down <= 1'b0;
      eff      <= '0;
    end else if (wrap) begin
      step_cnt <= env_step ? '0 : step_cnt + STEP_W'(1);
      env      <= env_nxt;
      env_down <= env_down_nxt;
      for (int i = 0; i < 3; i++) begin
        eff[i] <= prod[i][PW-1:8];
      end
    end
  end
`else
  assign eff = active;
`endif

  // Outputs: one clk behind pwm_cnt; strict compare means duty 2^N-1 is never 100%.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm           <= '0;
      period_strobe <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pwm[i] <= enable && (pwm_cnt < eff[i]);
      end
      period_strobe <= wrap;
    end
  end

  assign pwm_red   = pwm[0];
  assign pwm_green = pwm[1];
  assign pwm_blue  = pwm[2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_ctrl
// Purpose  : Self-checking bench for rgb_pwm_ctrl (COUNTER_BITS=4,
//            PRESCALER=2, period 32 clk). The reference model derives the
//            counter phase from the clk count since reset, with plain
//            arithmetic. It also tracks the shadow/active duties and the
//            pending flag. A duty table is checked by measuring high-time per
//            period. Corner-case sequences and random traffic follow.
// Revision : 1.0  initial release
// ============================================================================
module tb_rgb_pwm_ctrl;

  localparam int CB  = 4;
  localparam int PS  = 2;
  localparam int PER = PS * (1 << CB);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [CB-1:0] wr_red = '0, wr_green = '0, wr_blue = '0;
  logic          pwm_red, pwm_green, pwm_blue, period_strobe;

  always #5 clk = ~clk;

  rgb_pwm_ctrl #(
    .COUNTER_BITS(CB),
    .PRESCALER(PS),
    .BREATHE_STEP_PERIODS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_red(wr_red),
    .wr_green(wr_green),
    .wr_blue(wr_blue),
    .pwm_red(pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue(pwm_blue),
    .period_strobe(period_strobe)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int            n;            // index of the next clk edge since reset release
  bit            m_pending;
  logic [CB-1:0] m_shadow[3];
  logic [CB-1:0] m_active[3];
  bit            m_pwm[3];
  bit            m_strobe;
  int            hi_cnt[3];
  int            strobe_cnt;

  typedef struct {
    logic [CB-1:0] r, g, b;
    bit            en;
    int            hr, hg, hb;
  } vec_t;
  vec_t tbl[5];

  task automatic check_bit(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_pending = 1'b0;
    m_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
      m_pwm[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge, given the inputs present at that edge.
  task automatic model_edge(bit en, bit wv, logic [CB-1:0] r, g, b);
    int cnt;
    bit wrap;
    cnt  = (n / PS) % (1 << CB);
    wrap = ((n % PER) == PER - 1);
    for (int i = 0; i < 3; i++) m_pwm[i] = en && (cnt < int'(m_active[i]));
    m_strobe = wrap;
    if (!m_pending) begin
      if (wv) begin
        m_shadow[0] = r; m_shadow[1] = g; m_shadow[2] = b;
        m_pending = 1'b1;
      end
    end else if (wrap) begin
      for (int i = 0; i < 3; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
    n++;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
    strobe_cnt = 0;
  endtask

  task automatic step(bit en, bit wv, logic [CB-1:0] r, g, b);
    enable = en; wr_valid = wv; wr_red = r; wr_green = g; wr_blue = b;
    model_edge(en, wv, r, g, b);
    @(posedge clk);
    @(negedge clk);
    check_bit("pwm_red", pwm_red, m_pwm[0]);
    check_bit("pwm_green", pwm_green, m_pwm[1]);
    check_bit("pwm_blue", pwm_blue, m_pwm[2]);
    check_bit("period_strobe", period_strobe, m_strobe);
    check_bit("wr_ready", wr_ready, !m_pending);
    hi_cnt[0] += int'(pwm_red);
    hi_cnt[1] += int'(pwm_green);
    hi_cnt[2] += int'(pwm_blue);
    strobe_cnt += int'(period_strobe);
  endtask

  // Idle until the staged write has been applied (bounded).
  task automatic wait_ready(bit en, string name);
    int k;
    k = 0;
    while (!wr_ready && k < 3 * PER) begin
      step(en, 1'b0, '0, '0, '0);
      k++;
    end
    if (!wr_ready) check_int({name, "_ready_timeout"}, k, -1);
  endtask

  task automatic measure(bit en, int hr, int hg, int hb, string name);
    clear_counts();
    for (int i = 0; i < PER; i++) step(en, 1'b0, '0, '0, '0);
    check_int({name, "_hi_red"}, hi_cnt[0], hr);
    check_int({name, "_hi_green"}, hi_cnt[1], hg);
    check_int({name, "_hi_blue"}, hi_cnt[2], hb);
    check_int({name, "_strobes"}, strobe_cnt, 1);
  endtask

  initial begin
    tbl[0] = '{r: 4'd4,  g: 4'd0,  b: 4'd15, en: 1'b1, hr: 8,  hg: 0,  hb: 30};
    tbl[1] = '{r: 4'd1,  g: 4'd2,  b: 4'd3,  en: 1'b1, hr: 2,  hg: 4,  hb: 6};
    tbl[2] = '{r: 4'd15, g: 4'd15, b: 4'd15, en: 1'b0, hr: 0,  hg: 0,  hb: 0};
    tbl[3] = '{r: 4'd8,  g: 4'd7,  b: 4'd0,  en: 1'b1, hr: 16, hg: 14, hb: 0};
    tbl[4] = '{r: 4'd0,  g: 4'd15, b: 4'd1,  en: 1'b1, hr: 0,  hg: 30, hb: 2};

    // Reset state
    #1;
    check_bit("rst_pwm_red", pwm_red, 1'b0);
    check_bit("rst_pwm_green", pwm_green, 1'b0);
    check_bit("rst_pwm_blue", pwm_blue, 1'b0);
    check_bit("rst_strobe", period_strobe, 1'b0);
    check_bit("rst_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Duty table: write, wait for the wrap that applies it, measure one period
    for (int t = 0; t < 5; t++) begin
      step(tbl[t].en, 1'b1, tbl[t].r, tbl[t].g, tbl[t].b);
      wait_ready(tbl[t].en, $sformatf("tbl%0d", t));
      measure(tbl[t].en, tbl[t].hr, tbl[t].hg, tbl[t].hb, $sformatf("tbl%0d", t));
    end

    // Write held while pending: second write accepted only once ready returns
    begin
      int low;
      step(1'b1, 1'b1, 4'd2, 4'd3, 4'd4);
      low = 0;
      while (!wr_ready && low < 3 * PER) begin
        step(1'b1, 1'b1, 4'd9, 4'd9, 4'd9);
        low++;
      end
      check_bit("hold_ready_back", wr_ready, 1'b1);
      step(1'b1, 1'b1, 4'd9, 4'd9, 4'd9);
      check_bit("hold_second_accepted", wr_ready, 1'b0);
      wait_ready(1'b1, "hold");
      measure(1'b1, 18, 18, 18, "hold");
    end

    // Write accepted in the wrap clk: old duty for one full period, then new
    while ((n % PER) != PER - 1) step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 4'd5, 4'd5, 4'd5);
    measure(1'b1, 18, 18, 18, "wrapwr_old");
    check_bit("wrapwr_ready", wr_ready, 1'b1);
    measure(1'b1, 10, 10, 10, "wrapwr_new");

    // enable=0 mid-period: outputs low, strobes continue, resumes in phase
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, '0, '0);
    clear_counts();
    for (int i = 0; i < 2 * PER; i++) step(1'b0, 1'b0, '0, '0, '0);
    check_int("dis_hi_red", hi_cnt[0], 0);
    check_int("dis_strobes", strobe_cnt, 2);
    for (int i = 0; i < PER; i++) step(1'b1, 1'b0, '0, '0, '0);

    // Reset mid-period with a pending write
    step(1'b1, 1'b1, 4'd7, 4'd7, 4'd7);
    while ((n % PER) != 4) step(1'b1, 1'b0, '0, '0, '0);
    check_bit("pre_rst_pwm_red", pwm_red, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_pwm_red", pwm_red, 1'b0);
    check_bit("async_rst_pwm_blue", pwm_blue, 1'b0);
    check_bit("async_rst_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    measure(1'b1, 0, 0, 0, "post_rst");
    measure(1'b1, 0, 0, 0, "post_rst2");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 8) != 0, ($urandom % 4) == 0,
           CB'($urandom), CB'($urandom), CB'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
